// File: rtl/dmem_probe_arbiter.sv
// dmem_probe_arbiter: shares the data-memory port between the CPU load/store
// port and a byte-wide debug probe that reads words in CPU idle cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_gnt)
//   cpu_gnt                       CPU request accepted this cycle
//   cpu_rdata, cpu_rvalid         CPU read return, one cycle after grant
//   probe_in                      probe command/address byte, sampled every clk
//   probe_armed                   probe FSM is ARMED
//   probe_data, probe_valid       probe read return, one cycle after grant
//   mem_en/we/addr/wdata          data-memory request
//   mem_rdata                     data-memory read data, one cycle after read
module dmem_probe_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic [7:0]        probe_in,
    output logic              probe_armed,
    output logic [DATA_W-1:0] probe_data,
    output logic              probe_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, SYNC, ARMED} state_t;
    state_t            state, state_nx;
    logic              pending, pending_nx;
    logic [7:0]        paddr, paddr_nx;
    logic [3:0]        starve;
    logic              ctag, ptag;
    logic [DATA_W-1:0] chold, phold;
    logic              preempt, probe_gnt;

    assign preempt     = pending && (starve == 4'(STARVE_MAX));
    // Grants are suppressed while rst is high so nothing reaches memory during reset.
    assign cpu_gnt     = !rst && cpu_req && !preempt;
    assign probe_gnt   = !rst && pending && (!cpu_req || preempt);
    assign mem_en      = cpu_gnt || probe_gnt;
    assign mem_we      = cpu_gnt && cpu_we;
    assign mem_addr    = cpu_gnt ? cpu_addr : ADDR_W'(paddr);
    assign mem_wdata   = cpu_gnt ? cpu_wdata : '0;
    // A read in flight when reset arrives is dropped rather than returned.
    assign cpu_rvalid  = ctag && !rst;
    assign probe_valid = ptag && !rst;
    assign cpu_rdata   = cpu_rvalid ? mem_rdata : chold;
    assign probe_data  = probe_valid ? mem_rdata : phold;
    assign probe_armed = (state == ARMED);

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        paddr_nx   = paddr;
        case (state)
            IDLE: state_nx = (probe_in == 8'h14) ? SYNC : IDLE;
            SYNC: begin
                if (probe_in == 8'h01) begin
                    state_nx   = ARMED;
                    paddr_nx   = probe_in;
                    pending_nx = 1'b1;
                end else begin
                    state_nx = (probe_in == 8'h14) ? SYNC : IDLE;
                end
            end
            ARMED: begin
                if (probe_in == 8'hED) begin
                    state_nx   = IDLE;
                    pending_nx = 1'b0;
                end else if (probe_in != paddr) begin
                    // Newest address replaces any still-pending one.
                    paddr_nx   = probe_in;
                    pending_nx = 1'b1;
                end else if (probe_gnt) begin
                    pending_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 1'b0;
            paddr   <= '0;
            starve  <= '0;
            ctag    <= 1'b0;
            ptag    <= 1'b0;
            chold   <= '0;
            phold   <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            paddr   <= paddr_nx;
            starve  <= (!pending || probe_gnt) ? 4'd0 :
                       (starve == 4'(STARVE_MAX)) ? starve : starve + 4'd1;
            ctag    <= cpu_gnt && !cpu_we;
            ptag    <= probe_gnt;
            if (ctag) chold <= mem_rdata;
            if (ptag) phold <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_probe_arbiter.sv
// tb_dmem_probe_arbiter: scoreboard bench for dmem_probe_arbiter with a
// behavioural one-cycle-latency data memory.
module tb_dmem_probe_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [7:0]  probe_in;
    logic        probe_armed, probe_valid;
    logic [31:0] probe_data;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] probe_q[$];

    always #5 clk = ~clk;

    dmem_probe_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .probe_in(probe_in), .probe_armed(probe_armed),
        .probe_data(probe_data), .probe_valid(probe_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    // Scoreboard: every read return is matched against the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (cpu_rvalid === 1'b1) begin
            checks++;
            if (cpu_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_rvalid_unexpected got=%h exp=none", cpu_rdata);
            end else begin
                e = cpu_q.pop_front();
                if (cpu_rdata !== e) begin
                    failures++;
                    $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, e);
                end
            end
        end
        if (probe_valid === 1'b1) begin
            checks++;
            if (probe_q.size() == 0) begin
                failures++;
                $display("FAIL probe_valid_unexpected got=%h exp=none", probe_data);
            end else begin
                e = probe_q.pop_front();
                if (probe_data !== e) begin
                    failures++;
                    $display("FAIL probe_data got=%h exp=%h", probe_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        cpu_wdata = '0; probe_in = 8'h00;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, mem_en, mem_we, cpu_rvalid, probe_valid, probe_armed, cpu_rdata, probe_data} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%b/%h/%h exp=all zero",
                         cpu_gnt, mem_en, mem_we, cpu_rvalid, probe_valid, probe_armed, cpu_rdata, probe_data);
            end
            tick();
        end
        rst = 1'b0;
        cpu_q.push_back(32'hA000_0020);
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL first_gnt_after_reset got=%b exp=1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 8'h21;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midflight_gnt got=%b exp=1", cpu_gnt);
        end
        tick();
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_after_reset got=%b exp=0", cpu_rvalid);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_arm_probe();
        logic [7:0] seq [4] = '{8'hED, 8'h14, 8'h01, 8'h05};
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            probe_in = seq[i];
            @(negedge clk);
            checks++;
            if ({probe_armed, mem_en} !== 2'b00) begin
                failures++;
                $display("FAIL arm_pre_%0d got=armed%b en%b exp=armed0 en0", i, probe_armed, mem_en);
            end
            tick();
        end
        probe_in = seq[3];
        probe_q.push_back(32'hA000_0001);
        @(negedge clk);
        checks++;
        if ({probe_armed, mem_en, mem_we, mem_addr} !== {3'b110, 8'h01}) begin
            failures++;
            $display("FAIL arm_read_01 got=armed%b en%b we%b addr%h exp=armed1 en1 we0 addr01",
                     probe_armed, mem_en, mem_we, mem_addr);
        end
        tick();
        probe_q.push_back(32'd1234);
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 8'h05}) begin
            failures++;
            $display("FAIL arm_read_05 got=en%b addr%h exp=en1 addr05", mem_en, mem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL arm_no_repeat got=%b exp=0", mem_en);
        end
        tick();
        probe_in = 8'hED;
        tick();
    endtask

    task automatic test_bad_sync();
        logic [7:0] seq [7] = '{8'h14, 8'h02, 8'h01, 8'h00, 8'h14, 8'h14, 8'h01};
        cpu_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            probe_in = seq[i];
            @(negedge clk);
            checks++;
            if ({probe_armed, mem_en} !== 2'b00) begin
                failures++;
                $display("FAIL bad_sync_%0d got=armed%b en%b exp=armed0 en0", i, probe_armed, mem_en);
            end
            tick();
        end
        probe_q.push_back(32'hA000_0001);
        @(negedge clk);
        checks++;
        if ({probe_armed, mem_en, mem_addr} !== {2'b11, 8'h01}) begin
            failures++;
            $display("FAIL resync_armed got=armed%b en%b addr%h exp=armed1 en1 addr01",
                     probe_armed, mem_en, mem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL resync_idle got=%b exp=0", mem_en);
        end
        tick();
    endtask

    task automatic test_starvation();
        int ng = 0;
        bit prev_g = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0;
        probe_in = 8'h09;
        for (int k = 0; k < 9; k++) begin
            bit g = (k != SM + 1);
            cpu_addr = 8'h40 + 8'(ng);
            if (g) cpu_q.push_back(32'hA000_0040 + 32'(ng));
            else probe_q.push_back(32'hA000_0009);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== g || mem_en !== 1'b1 || (!g && mem_addr !== 8'h09)) begin
                failures++;
                $display("FAIL starve_cycle_%0d got=gnt%b en%b addr%h exp=gnt%b en1", k, cpu_gnt, mem_en, mem_addr, g);
            end
            checks++;
            if (cpu_rvalid !== (k > 0 && prev_g)) begin
                failures++;
                $display("FAIL starve_rvalid_%0d got=%b exp=%b", k, cpu_rvalid, k > 0 && prev_g);
            end
            prev_g = g;
            if (g) ng++;
            tick();
        end
        cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h10, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL cpu_write got=gnt%b we%b addr%h wdata%h exp=gnt1 we1 addr10 wdata deadbeef",
                     cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        cpu_we = 1'b0; cpu_wdata = '0;
        cpu_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, mem_we, cpu_rvalid} !== 3'b100) begin
            failures++;
            $display("FAIL cpu_read got=gnt%b we%b rvalid%b exp=gnt1 we0 rvalid0", cpu_gnt, mem_we, cpu_rvalid);
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, probe_valid} !== 2'b10) begin
            failures++;
            $display("FAIL cpu_read_return got=rvalid%b pvalid%b exp=rvalid1 pvalid0", cpu_rvalid, probe_valid);
        end
        tick();
    endtask

    task automatic test_overwrite_disarm();
        int pg = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
        for (int k = 0; k < 6; k++) begin
            bit g = (k != SM + 1);
            probe_in = (k == 0) ? 8'h03 : 8'h07;
            if (g) cpu_q.push_back(32'hA000_0050);
            else probe_q.push_back(32'hA000_0007);
            @(negedge clk);
            if (mem_en && !cpu_gnt) pg++;
            checks++;
            if (cpu_gnt !== g || (!g && mem_addr !== 8'h07)) begin
                failures++;
                $display("FAIL overwrite_cycle_%0d got=gnt%b addr%h exp=gnt%b addr07", k, cpu_gnt, mem_addr, g);
            end
            tick();
        end
        probe_in = 8'hED; cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({probe_valid, probe_armed, mem_en} !== 3'b110) begin
            failures++;
            $display("FAIL disarm_valid got=pvalid%b armed%b en%b exp=pvalid1 armed1 en0",
                     probe_valid, probe_armed, mem_en);
        end
        tick();
        probe_in = 8'h07;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_en && !cpu_gnt) pg++;
            checks++;
            if ({probe_armed, mem_en} !== 2'b00) begin
                failures++;
                $display("FAIL disarmed_%0d got=armed%b en%b exp=armed0 en0", k, probe_armed, mem_en);
            end
            tick();
        end
        checks++;
        if (pg != 1) begin
            failures++;
            $display("FAIL overwrite_probe_reads got=%0d exp=1", pg);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[5] = 32'd1234;
        test_reset();
        test_arm_probe();
        test_bad_sync();
        test_starvation();
        test_cpu_write_read();
        test_overwrite_disarm();
        tick();
        checks++;
        if (cpu_q.size() != 0 || probe_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=cpu%0d probe%0d exp=cpu0 probe0", cpu_q.size(), probe_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
